rainbow_lfsr_gen: RTL and testbench

RAINBOW_LFSR_GEN -- requirements
Module: rainbow_lfsr_gen

---
 rtl/rainbow_pkg.sv | 18 +
 rtl/rainbow_lfsr_step.sv | 25 ++
 rtl/rainbow_lfsr_gen.sv | 129 ++++++++++++
 tb/tb_rainbow_lfsr_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rainbow_pkg.sv
// Shared types and default constants for the rainbow LFSR word generator.
package rainbow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PRESENT = 2'd2
    } rng_state_e;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h5A08;

    // Shift counter width; a single-step word still needs a 1-bit counter.
    function automatic int unsigned count_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/rainbow_lfsr_step.sv
// One Fibonacci LFSR shift: feedback is the parity of the tapped state bits,
// shifted in at the LSB.
module rainbow_lfsr_step
    import rainbow_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] tapped;
    logic             feedback;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tapped[gi] = TAPS[gi] & state_i[gi];
        end
    endgenerate

    assign feedback = ^tapped;
    assign next_o   = {state_i[WIDTH-2:0], feedback};

endmodule

// File: rtl/rainbow_lfsr_gen.sv
// LFSR random word generator: STEPS shifts per word, valid/ready output hold,
// seed loading with lock-up protection and a wrap pulse on sequence return.
module rainbow_lfsr_gen
    import rainbow_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter int unsigned      STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rng_ready,
    output logic             rng_valid,
    output logic [WIDTH-1:0] rng_out,
    output logic             wrap
);

    localparam int unsigned     CW         = count_width(STEPS);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(STEPS - 1);

    rng_state_e       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] seed_act_q, seed_act_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_sel;
    logic             handshake;
    logic             shift_go;
    logic             last_shift;

    rainbow_lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state_i (lfsr_q),
        .next_o  (lfsr_next)
    );

    // rng_valid is high for the whole PRESENT stay, so ready alone completes it.
    assign handshake  = (state_q == ST_PRESENT) && rng_ready;
    assign shift_go   = !seed_load && enable && ((state_q != ST_PRESENT) || rng_ready);
    assign last_shift = shift_go && (count_q == LAST_COUNT);
    assign seed_sel   = (seed_in == '0) ? SEED : seed_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            seed_act_q <= SEED;
            count_q    <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_act_q <= seed_act_d;
            count_q    <= count_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (seed_load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = last_shift ? ST_PRESENT : ST_RUN;
                end
                ST_RUN: begin
                    if (last_shift) state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (rng_ready) begin
                        if (!enable)        state_d = ST_IDLE;
                        else if (last_shift) state_d = ST_PRESENT;
                        else                 state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lfsr_d     = lfsr_q;
        seed_act_d = seed_act_q;
        count_d    = count_q;
        out_d      = out_q;
        valid_d    = valid_q;
        wrap_d     = 1'b0;
        if (seed_load) begin
            lfsr_d     = seed_sel;
            seed_act_d = seed_sel;
            count_d    = '0;
            valid_d    = 1'b0;
        end else begin
            if (handshake) valid_d = 1'b0;
            if (shift_go) begin
                lfsr_d = lfsr_next;
                wrap_d = (lfsr_next == seed_act_q);
                if (last_shift) begin
                    count_d = '0;
                    out_d   = lfsr_next;
                    valid_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    assign rng_valid = valid_q;
    assign rng_out   = out_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_rainbow_lfsr_gen.sv
// Self-checking bench: constant vector table, directed multi-cycle sequences,
// randomized traffic against a transaction-level model, and a full-period wrap run.
module tb_rainbow_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        rng_ready;
    logic        v1, w1, v4, w4;
    logic [15:0] o1, o4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rainbow_lfsr_gen dut1 (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .rng_ready(rng_ready),
        .rng_valid(v1), .rng_out(o1), .wrap(w1)
    );

    rainbow_lfsr_gen #(.STEPS(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .rng_ready(rng_ready),
        .rng_valid(v4), .rng_out(o4), .wrap(w4)
    );

    // Transaction-level reference: a word is "held" until taken; shifting
    // is allowed whenever nothing is held or the held word is being taken.
    typedef struct packed {
        logic [15:0] lfsr;
        logic [15:0] act;
        logic [15:0] out;
        logic [7:0]  done;
        logic        hold;
        logic        wrap;
    } mdl_t;

    mdl_t m [2];

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] t;
        logic        fb;
        t  = 16'hB400;
        fb = 1'b0;
        for (int i = 0; i < 16; i++) if (t[i]) fb = fb ^ s[i];
        return {s[14:0], fb};
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.lfsr = 16'h5A08;
        r.act  = 16'h5A08;
        r.out  = 16'h0000;
        r.done = 8'd0;
        r.hold = 1'b0;
        r.wrap = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t s, input int steps, input logic en,
                                      input logic rdy, input logic sl, input logic [15:0] sin);
        mdl_t n;
        logic go;
        n      = s;
        n.wrap = 1'b0;
        if (sl) begin
            n.lfsr = (sin == 16'h0000) ? 16'h5A08 : sin;
            n.act  = n.lfsr;
            n.done = 8'd0;
            n.hold = 1'b0;
            return n;
        end
        go = en && (!s.hold || rdy);
        if (s.hold && rdy) n.hold = 1'b0;
        if (go) begin
            n.lfsr = lfsr_adv(s.lfsr);
            n.done = s.done + 8'd1;
            n.wrap = (n.lfsr == s.act);
            if (int'(n.done) == steps) begin
                n.out  = n.lfsr;
                n.hold = 1'b1;
                n.done = 8'd0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m[0] <= mdl_reset();
            m[1] <= mdl_reset();
        end else begin
            m[0] <= mdl_next(m[0], 1, enable, rng_ready, seed_load, seed_in);
            m[1] <= mdl_next(m[1], 4, enable, rng_ready, seed_load, seed_in);
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk1 ({tag, " valid1"}, v1, m[0].hold);
        chk16({tag, " out1"},   o1, m[0].out);
        chk1 ({tag, " wrap1"},  w1, m[0].wrap);
        chk1 ({tag, " valid4"}, v4, m[1].hold);
        chk16({tag, " out4"},   o4, m[1].out);
        chk1 ({tag, " wrap4"},  w4, m[1].wrap);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic rdy, input logic sl, input logic [15:0] sin);
        enable    = en;
        rng_ready = rdy;
        seed_load = sl;
        seed_in   = sin;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        sl;
        logic [15:0] sin;
        logic        ev;
        logic [15:0] eo;
        logic        ew;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int          en_pat [6];
        int          wrap_cnt, wrap_pos, mism4;
        logic [15:0] wrap_out;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hB411, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h6822, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h6822, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h6822, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hD045, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hD045, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'hD045, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0002, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hB411, 1'b0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        chk1 ("reset valid1", v1, 1'b0);
        chk16("reset out1",   o1, 16'h0000);
        chk1 ("reset wrap1",  w1, 1'b0);
        chk1 ("reset valid4", v4, 1'b0);
        chk16("reset out4",   o4, 16'h0000);
        reset = 1'b1;

        // Vector table against the single-step instance
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].en, tbl[i].rdy, tbl[i].sl, tbl[i].sin);
            tick();
            $display("vec %0d en=%0b rdy=%0b sl=%0b sin=%04h -> valid=%0b out=%04h wrap=%0b",
                     i, tbl[i].en, tbl[i].rdy, tbl[i].sl, tbl[i].sin, v1, o1, w1);
            chk1 ($sformatf("vec%0d valid", i), v1, tbl[i].ev);
            chk16($sformatf("vec%0d out", i),   o1, tbl[i].eo);
            chk1 ($sformatf("vec%0d wrap", i),  w1, tbl[i].ew);
            chk_model($sformatf("vec%0d model", i));
        end

        // Four-step word with enable gaps and a stalled consumer
        reset_pulse();
        en_pat = '{1, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            drive(en_pat[i] != 0, 1'b0, 1'b0, 16'h0000);
            tick();
            $display("steps4 cyc %0d en=%0d -> valid=%0b out=%04h", i, en_pat[i], v4, o4);
            chk1($sformatf("steps4 cyc%0d valid", i), v4, (i == 5));
            chk_model($sformatf("steps4 cyc%0d model", i));
        end
        chk16("steps4 word", o4, 16'hA08A);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            tick();
            $display("steps4 hold %0d -> valid=%0b out=%04h", i, v4, o4);
            chk1 ($sformatf("steps4 hold%0d valid", i), v4, 1'b1);
            chk16($sformatf("steps4 hold%0d out", i),   o4, 16'hA08A);
        end

        // Asynchronous reset while presenting, no clock edge in between
        #2;
        reset = 1'b0;
        #1;
        $display("async reset -> valid1=%0b out1=%04h valid4=%0b out4=%04h", v1, o1, v4, o4);
        chk1 ("async valid4", v4, 1'b0);
        chk16("async out4",   o4, 16'h0000);
        chk1 ("async valid1", v1, 1'b0);
        chk16("async out1",   o1, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            tick();
            $display("post-reset cyc %0d -> out1=%04h valid4=%0b out4=%04h", i, o1, v4, o4);
            if (i == 1) begin
                chk1 ("post-reset valid1", v1, 1'b1);
                chk16("post-reset out1",   o1, 16'hB411);
            end
            chk_model($sformatf("post-reset cyc%0d", i));
        end
        chk16("post-reset out4", o4, 16'hA08A);

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 3,
                  ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            tick();
            chk_model($sformatf("rand%0d", i));
        end
        $display("random phase done: total=%0d bad=%0d", total, bad);

        // Full-period run: wrap must fire once, at shift 65535
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        reset_pulse();
        wrap_cnt = 0;
        wrap_pos = 0;
        mism4    = 0;
        wrap_out = 16'h0000;
        for (int k = 1; k <= 65540; k++) begin
            tick();
            if (w1) begin
                wrap_cnt++;
                wrap_pos = k;
                wrap_out = o1;
            end
            if (w4 !== m[1].wrap) mism4++;
        end
        $display("wrap run -> pulses=%0d at shift %0d out=%04h steps4 wrap mismatches=%0d",
                 wrap_cnt, wrap_pos, wrap_out, mism4);
        chk_int("wrap count",    wrap_cnt, 1);
        chk_int("wrap position", wrap_pos, 65535);
        chk16  ("wrap word",     wrap_out, 16'h5A08);
        chk_int("wrap4 vs model", mism4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
